pipe_hazard_ctrl: RTL

- Drives the per-stage `en` and `clear` inputs of the flopenrc pipeline registers (fetch/decode, decode/execute, execute/memory).
- It is the control end of the flopenrc interface: it decides when stage registers hold (stall) and when they zero (flush).
- Handles four events:
  - load-use bubbles;
  - taken-branch flushes;
  - multi-cycle vector execute occupancy;
  - data-memory back-pressure, including a flush that arrives while memory is busy.
- Also exports a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: drives flopenrc en/clear for the F/D, D/E and E/M stage registers
// and keeps a saturating stall-cycle counter for performance debug.
module pipe_hazard_ctrl #(
  parameter int unsigned VLAT = 4,
  parameter int unsigned SCW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_use,
  input  logic           vec_start,
  input  logic           branch_taken,
  input  logic           mem_busy,
  output logic           en_f,
  output logic           en_d,
  output logic           en_e,
  output logic           clr_d,
  output logic           clr_e,
  output logic           vec_busy,
  output logic [SCW-1:0] stall_cnt
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    VEC = 2'd1,
    MEM = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pend_flush, pend_nx;

  // State, occupancy counter and pending-flush registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      cnt        <= '0;
      pend_flush <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pend_flush <= pend_nx;
    end
  end

  // Next state and stage controls; reset forces free-running, unflushed stages
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend_flush;
    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    clr_d    = 1'b0;
    clr_e    = 1'b0;
    vec_busy = 1'b0;
    if (!reset) begin
      case (state)
        VEC: begin
          en_f     = 1'b0;
          en_d     = 1'b0;
          en_e     = 1'b0;
          vec_busy = 1'b1;
          cnt_nx   = cnt - CW'(1);
          // Occupancy over: hand off to MEM if memory is still stalling
          if (cnt == CW'(1)) begin
            state_nx = mem_busy ? MEM : RUN;
          end
        end
        default: begin
          if (mem_busy) begin
            en_f     = 1'b0;
            en_d     = 1'b0;
            en_e     = 1'b0;
            state_nx = MEM;
            if (branch_taken) begin
              pend_nx = 1'b1;
            end
          end else begin
            state_nx = RUN;
            pend_nx  = 1'b0;
            // A deferred flush and a fresh branch collapse into one clear
            if (pend_flush || branch_taken) begin
              clr_d = 1'b1;
              clr_e = 1'b1;
            end else if (load_use) begin
              en_f  = 1'b0;
              en_d  = 1'b0;
              clr_e = 1'b1;
            end
            if (vec_start && (VLAT > 1)) begin
              cnt_nx   = CW'(VLAT - 1);
              state_nx = VEC;
            end
          end
        end
      endcase
    end
  end

  // Saturating count of cycles where decode is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!en_d && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + SCW'(1);
    end
  end

endmodule
